// File: rtl/fpga_config_loader.sv
// Host-word to CRAM scan-chain serializer.
// Shifts exactly CHAIN_LENGTH bits LSB-first, then releases the fabric.
module fpga_config_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 1024
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_data_out,
  output logic                  config_en,
  output logic                  busy,
  output logic                  done,
  output logic                  le_nrst,
  output logic                  le_en
);

  localparam int CW = $clog2(CHAIN_LENGTH + 1);
  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam int XW = ((CW > BW) ? CW : BW) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]         left_q, left_d;
  logic [CW-1:0]         sent_q, sent_d;

  logic          shift;
  logic          accept;
  logic [XW-1:0] rem_x;
  logic [XW-1:0] left_x;
  logic [XW-1:0] after_x;
  logic [BW-1:0] load_n;

  assign shift  = (state_q == LOAD) && (left_q != '0);
  assign rem_x  = XW'(CHAIN_LENGTH) - XW'(sent_q);
  assign left_x = XW'(left_q);

  // Bits still owed to the chain once this cycle's shift (if any) lands.
  assign after_x = rem_x - left_x;
  assign load_n  = (after_x < XW'(WORD_WIDTH)) ?
                   BW'(after_x) : BW'(WORD_WIDTH);

  assign word_ready = (state_q == LOAD) && !abort &&
                      (left_q <= BW'(1)) && (rem_x > left_x);
  assign accept     = word_ready && word_valid;

  assign config_en       = shift;
  assign config_data_out = shift & sreg_q[0];
  assign busy            = (state_q == LOAD);
  assign done            = (state_q == DONE);
  assign le_nrst         = (state_q == DONE);
  assign le_en           = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    left_d  = left_q;
    sent_d  = sent_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          sreg_d  = '0;
          left_d  = '0;
          sent_d  = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          sreg_d  = '0;
          left_d  = '0;
          sent_d  = '0;
        end else begin
          if (shift) begin
            sreg_d = sreg_q >> 1;
            left_d = left_q - BW'(1);
            sent_d = sent_q + CW'(1);
          end
          if (accept) begin
            sreg_d = word_in;
            left_d = load_n;
          end
          if (sent_d == CW'(CHAIN_LENGTH)) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      left_q  <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      left_q  <= left_d;
      sent_q  <= sent_d;
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Scoreboard bench for fpga_config_loader.
// Two instances: 24-bit chain and 20-bit chain (partial last word).
module tb_fpga_config_loader;

  logic clk;
  logic nrst;
  logic start, abort, valid;
  logic [7:0] word;
  int sel;

  logic rdy_a, cdo_a, cen_a, busy_a, done_a, lnr_a, len_a;
  logic rdy_b, cdo_b, cen_b, busy_b, done_b, lnr_b, len_b;
  logic ready, cdo, cen, busy, done, lnr, len;

  logic start_a, abort_a, valid_a;
  logic start_b, abort_b, valid_b;

  assign start_a = start && (sel == 0);
  assign abort_a = abort && (sel == 0);
  assign valid_a = valid && (sel == 0);
  assign start_b = start && (sel == 1);
  assign abort_b = abort && (sel == 1);
  assign valid_b = valid && (sel == 1);

  assign ready = (sel == 1) ? rdy_b  : rdy_a;
  assign cdo   = (sel == 1) ? cdo_b  : cdo_a;
  assign cen   = (sel == 1) ? cen_b  : cen_a;
  assign busy  = (sel == 1) ? busy_b : busy_a;
  assign done  = (sel == 1) ? done_b : done_a;
  assign lnr   = (sel == 1) ? lnr_b  : lnr_a;
  assign len   = (sel == 1) ? len_b  : len_a;

  fpga_config_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(24)) u_a (
    .clk(clk), .nrst(nrst), .start(start_a), .abort(abort_a),
    .word_in(word), .word_valid(valid_a), .word_ready(rdy_a),
    .config_data_out(cdo_a), .config_en(cen_a), .busy(busy_a),
    .done(done_a), .le_nrst(lnr_a), .le_en(len_a)
  );

  fpga_config_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(20)) u_b (
    .clk(clk), .nrst(nrst), .start(start_b), .abort(abort_b),
    .word_in(word), .word_valid(valid_b), .word_ready(rdy_b),
    .config_data_out(cdo_b), .config_en(cen_b), .busy(busy_b),
    .done(done_b), .le_nrst(lnr_b), .le_en(len_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic q[$];
  int errors = 0;
  int checks = 0;
  int mon_err = 0;
  int mon_chk = 0;
  int en_cnt = 0;
  int run = 0;
  int last_run = 0;
  int base = 0;

  always @(negedge clk) begin
    if (nrst) begin
      if (cen) begin
        en_cnt = en_cnt + 1;
        run = run + 1;
        mon_chk = mon_chk + 1;
        if (q.size() == 0) begin
          mon_err = mon_err + 1;
          $display("FAIL extra_bit: got %0b with no expected bit", cdo);
        end else begin
          logic e;
          e = q.pop_front();
          if (cdo !== e) begin
            mon_err = mon_err + 1;
            $display("FAIL serial_bit #%0d: got %0b expected %0b",
                     en_cnt, cdo, e);
          end
        end
      end else begin
        if (run != 0) last_run = run;
        run = 0;
        mon_chk = mon_chk + 1;
        if (cdo !== 1'b0) begin
          mon_err = mon_err + 1;
          $display("FAIL idle_data: got %0b expected 0", cdo);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = en_cnt;
  endtask

  task automatic put_word(input logic [7:0] w, input int n);
    bit ok;
    ok = 0;
    word = w;
    valid = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      #1;
      if (ready) begin
        for (int i = 0; i < n; i++) q.push_back(w[i]);
        ok = 1;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input string tag, input int cl);
    bit seen, prev, rdy_seen;
    seen = 0;
    prev = 0;
    rdy_seen = 0;
    for (int t = 0; t < 300; t++) begin
      if (done) begin
        seen = 1;
        break;
      end
      rdy_seen = rdy_seen | ready;
      prev = cen;
      @(negedge clk);
    end
    #1;
    chk({tag, "_done_seen"}, int'(seen), 1);
    chk({tag, "_done_after_last_bit"}, int'(prev), 1);
    chk({tag, "_en_cycles"}, en_cnt - base, cl);
    chk({tag, "_queue_empty"}, q.size(), 0);
    chk({tag, "_no_ready_after_last"}, int'(rdy_seen), 0);
    chk({tag, "_release"}, int'({lnr, len, cen, busy}), 4'b1100);
  endtask

  initial begin
    nrst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    valid = 1'b0;
    word = '0;
    sel = 0;
    #12;
    chk("reset_outputs",
        int'({ready, cen, cdo, busy, done, lnr, len}), 0);
    @(negedge clk);
    nrst = 1'b1;

    // T2: zero-bubble streaming, 24-bit chain
    do_start();
    chk("t2_busy", int'(busy), 1);
    put_word(8'hA5, 8);
    put_word(8'h3C, 8);
    put_word(8'hFF, 8);
    wait_done("t2", 24);
    chk("t2_run_len", last_run, 24);

    // T3: partial last word on 20-bit chain
    sel = 1;
    do_start();
    put_word(8'h01, 8);
    put_word(8'h02, 8);
    put_word(8'hF7, 4);
    wait_done("t3", 20);

    // T4: random bubbles between words
    sel = 0;
    do_start();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] w;
      w = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      put_word(w, 8);
    end
    wait_done("t4", 24);

    // T5: abort after 10 shifted bits
    do_start();
    put_word(8'hA5, 8);
    put_word(8'h3C, 8);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    valid = 1'b1;
    word = 8'hFF;
    #1;
    chk("t5_abort_blocks_ready", int'(ready), 0);
    @(negedge clk);
    abort = 1'b0;
    valid = 1'b0;
    q.delete();
    chk("t5_bits_before_abort", en_cnt - base, 11);
    chk("t5_idle_outputs", int'({busy, done, lnr, len, cen}), 0);
    do_start();
    put_word(8'h5A, 8);
    put_word(8'hC3, 8);
    put_word(8'h0F, 8);
    wait_done("t5", 24);

    // T6: reconfigure from DONE
    do_start();
    chk("t6_fabric_held", int'({lnr, len, done, busy}), 4'b0001);
    put_word(8'h00, 8);
    put_word(8'h81, 8);
    put_word(8'h7E, 8);
    wait_done("t6", 24);

    // T1: async reset in the middle of a shift
    do_start();
    put_word(8'hFF, 8);
    chk("t1_pre_en", int'(cen), 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("t1_async_outputs",
        int'({ready, cen, cdo, busy, done, lnr, len}), 0);
    q.delete();
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("t1_idle_after", int'({busy, done, cen}), 0);

    errors = errors + mon_err;
    checks = checks + mon_chk;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
